// File: rtl/interrupt_ack_sequencer.sv
// Interrupt acknowledge sequencer: priority resolve, two-pulse INTA handshake, vector
// presentation and EOI decode driving a single-level in-service register.
module interrupt_ack_sequencer #(
  parameter int unsigned NUM_IR         = 8,
  parameter int unsigned SPURIOUS_LEVEL = 7,
  localparam int unsigned LVL_W         = $clog2(NUM_IR)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IR-1:0]   interrupt_request,
  input  logic [NUM_IR-1:0]   interrupt_mask,
  input  logic                inta_n,
  input  logic                eoi_valid,
  input  logic                eoi_specific,
  input  logic [LVL_W-1:0]    eoi_level,
  input  logic                auto_eoi,
  input  logic                rotate_on_eoi,
  input  logic [7-LVL_W:0]    vector_base,
  output logic                int_out,
  output logic [NUM_IR-1:0]   interrupt,
  output logic                latch_in_service,
  output logic [NUM_IR-1:0]   end_of_interrupt,
  output logic [7:0]          data_out,
  output logic                data_out_en
);

  typedef enum logic [2:0] {StIdle, StReq, StAck1, StAck2, StVec, StService} state_e;

  state_e             state_q, state_d;
  logic               inta_q;
  logic [LVL_W-1:0]   prio_base_q, prio_base_d;
  logic [LVL_W-1:0]   sel_level_q, sel_level_d;
  logic               spurious_q, spurious_d;
  logic               eoi_q, eoi_d;

  logic [NUM_IR-1:0]  req_active;
  logic               any_req;
  logic               inta_fall, inta_rise;
  logic [LVL_W-1:0]   base_eff;
  logic [LVL_W-1:0]   winner;
  logic               found;
  logic               eoi_take;
  logic               in_service;
  logic [NUM_IR-1:0]  sel_onehot;

  assign req_active = interrupt_request & ~interrupt_mask;
  assign any_req    = |req_active;
  assign inta_fall  = inta_q & ~inta_n;
  assign inta_rise  = ~inta_q & inta_n;
  assign base_eff   = rotate_on_eoi ? prio_base_q : '0;

  // Scan upward from the current priority base, wrapping past the top level.
  always_comb begin
    int unsigned idx;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_IR; i++) begin
      idx = 32'(base_eff) + i;
      if (idx >= NUM_IR) idx = idx - NUM_IR;
      if (!found && req_active[LVL_W'(idx)]) begin
        found  = 1'b1;
        winner = LVL_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      inta_q      <= 1'b1;
      prio_base_q <= '0;
      sel_level_q <= '0;
      spurious_q  <= 1'b0;
      eoi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_q      <= inta_n;
      prio_base_q <= prio_base_d;
      sel_level_q <= sel_level_d;
      spurious_q  <= spurious_d;
      eoi_q       <= eoi_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_level_d = sel_level_q;
    spurious_d  = spurious_q;
    eoi_take    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (inta_fall) begin
          state_d     = StAck1;
          sel_level_d = LVL_W'(SPURIOUS_LEVEL);
          spurious_d  = 1'b1;
        end else if (any_req) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (inta_fall) begin
          state_d     = StAck1;
          sel_level_d = any_req ? winner : LVL_W'(SPURIOUS_LEVEL);
          spurious_d  = ~any_req;
        end else if (!any_req) begin
          state_d = StIdle;
        end
      end
      StAck1: if (inta_rise) state_d = StAck2;
      StAck2: if (inta_fall) state_d = StVec;
      StVec: begin
        if (inta_rise) begin
          if (spurious_q) begin
            state_d = StIdle;
          end else if (auto_eoi) begin
            state_d  = StIdle;
            eoi_take = 1'b1;
          end else begin
            state_d = StService;
          end
        end
      end
      StService: begin
        if (eoi_valid && (!eoi_specific || eoi_level == sel_level_q)) begin
          state_d  = StIdle;
          eoi_take = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    eoi_d = eoi_take;
    if (!rotate_on_eoi) begin
      prio_base_d = '0;
    end else if (eoi_take) begin
      prio_base_d = (sel_level_q == LVL_W'(NUM_IR - 1)) ? '0 : sel_level_q + 1'b1;
    end else begin
      prio_base_d = prio_base_q;
    end
  end

  always_comb begin
    sel_onehot       = {{(NUM_IR-1){1'b0}}, 1'b1} << sel_level_q;
    in_service       = !spurious_q && (state_q == StAck1 || state_q == StAck2 ||
                                       state_q == StVec  || state_q == StService);
    int_out          = (state_q == StReq);
    interrupt        = in_service ? sel_onehot : '0;
    latch_in_service = in_service;
    end_of_interrupt = eoi_q ? sel_onehot : '0;
    data_out_en      = (state_q == StVec);
    data_out         = data_out_en ? {vector_base, sel_level_q} : 8'h00;
  end

endmodule
